// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with lane steering, load extension and pipeline stall
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module mem_lsu #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_load,
  input  logic              ex_mem_store,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  output logic              mem_stall,
  output logic              mem_done,
  output logic              misalign_exc,
  output logic              bus_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] mem_DM_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_we, r_uns;
  logic [1:0]        r_size, r_lo;
  logic              w_is_mem, w_misaligned, w_start, w_expired;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_lane, w_load_data;
  logic              w_ext_b, w_ext_h;

  assign w_is_mem = ex_mem_valid & (ex_mem_load | ex_mem_store);

  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = ex_mem_wdata;
    case (ex_mem_size)
      2'b00: begin
        w_be    = 4'b0001 << ex_mem_addr[1:0];
        w_wdata = {4{ex_mem_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = ex_mem_addr[0];
        w_be         = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{ex_mem_wdata[15:0]}};
      end
      default: w_misaligned = (ex_mem_addr[1:0] != 2'b00);
    endcase
  end

  assign w_start = w_is_mem & ~w_misaligned;

  // Captured size/offset select and extend the returned lane
  assign w_lane  = dm_rdata >> {r_lo, 3'b000};
  assign w_ext_b = ~r_uns & w_lane[7];
  assign w_ext_h = ~r_uns & w_lane[15];

  always_comb begin
    case (r_size)
      2'b00:   w_load_data = {{(DATA_W-8){w_ext_b}}, w_lane[7:0]};
      2'b01:   w_load_data = {{(DATA_W-16){w_ext_h}}, w_lane[15:0]};
      default: w_load_data = dm_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  assign w_expired = (r_state == S_BUSY) & ~dm_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_expired;
      if (r_state == S_IDLE) r_cnt <= '0;
      else if (r_state == S_BUSY && !dm_ack) r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expired = 1'b0;
  assign bus_err   = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_next       = r_state;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    misalign_exc = 1'b0;
    dm_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_stall    = w_start;
        misalign_exc = w_is_mem & w_misaligned;
        if (w_start) w_next = S_BUSY;
      end
      S_BUSY: begin
        mem_stall = 1'b1;
        dm_req    = 1'b1;
        if (dm_ack || w_expired) w_next = S_DONE;
      end
      S_DONE: begin
        mem_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign dm_we = r_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'b00;
      r_lo       <= 2'b00;
      dm_addr    <= '0;
      dm_be      <= 4'b0000;
      dm_wdata   <= '0;
      mem_DM_out <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_start) begin
        r_we     <= ex_mem_store;
        r_uns    <= ex_mem_unsigned;
        r_size   <= ex_mem_size;
        r_lo     <= ex_mem_addr[1:0];
        dm_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
        dm_be    <= w_be;
        dm_wdata <= w_wdata;
      end
      if (r_state == S_BUSY && !r_we) begin
        if (dm_ack) mem_DM_out <= w_load_data;
        else if (w_expired) mem_DM_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed bench for mem_lsu with a transaction-level expectation model
module tb_mem_lsu;
  localparam int TMO = 16;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ex_mem_valid = 0, ex_mem_load = 0, ex_mem_store = 0, ex_mem_unsigned = 0;
  logic [1:0]  ex_mem_size = 0;
  logic [31:0] ex_mem_addr = 0, ex_mem_wdata = 0, dm_rdata = 0;
  logic        dm_ack = 0;
  logic        mem_stall, mem_done, misalign_exc, bus_err, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, mem_DM_out;
  logic [3:0]  dm_be;

  mem_lsu dut (
    .clk(clk), .rst(rst), .ex_mem_valid(ex_mem_valid), .ex_mem_load(ex_mem_load),
    .ex_mem_store(ex_mem_store), .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata), .mem_stall(mem_stall),
    .mem_done(mem_done), .misalign_exc(misalign_exc), .bus_err(bus_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .mem_DM_out(mem_DM_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int n_stall_seen = 0, n_req_seen = 0;
  bit chk_en = 0, chk_bus = 1;
  logic        e_stall = 0, e_req = 0, e_done = 0, e_mis = 0, e_berr = 0, e_we = 0;
  logic [31:0] e_out = 0, m_out = 0, e_addr = 0, e_wdata = 0;
  logic [3:0]  e_be = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic [3:0]  last_be = 0;
  logic        last_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int lo = int'(a % 4);
    return 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, m;
    int n = nbytes(sz);
    m = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v = (rd >> (8 * (a % 4))) & m;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  // Every cycle the DUT outputs are compared with the current expectation
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("mem_stall", 32'(mem_stall), 32'(e_stall));
        chk("dm_req", 32'(dm_req), 32'(e_req));
        chk("mem_done", 32'(mem_done), 32'(e_done));
        chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
        chk("bus_err", 32'(bus_err), 32'(e_berr));
        chk("mem_DM_out", mem_DM_out, e_out);
        if (chk_bus) begin
          chk("dm_addr", dm_addr, e_addr);
          chk("dm_be", 32'(dm_be), 32'(e_be));
          chk("dm_wdata", dm_wdata, e_wdata);
          chk("dm_we", 32'(dm_we), 32'(e_we));
        end
      end
      if (mem_stall === 1'b1) n_stall_seen++;
      if (dm_req === 1'b1) begin
        n_req_seen++;
        last_addr = dm_addr; last_be = dm_be; last_wdata = dm_wdata; last_we = dm_we;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) begin
      cyc();
      ex_mem_valid = 0; dm_ack = ack;
      e_stall = 0; e_req = 0; e_done = 0; e_mis = 0; e_berr = 0; chk_bus = 0; e_out = m_out;
    end
    @(negedge clk);
    #1;
  endtask

  // k: BUSY cycle index carrying dm_ack (-1 = never); rst_at: BUSY index at which reset hits
  task automatic access(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int k, input int rst_at);
    bit mis, ismem, tmo_hit;
    ismem = ld | st;
    mis = model_mis(sz, a);
    tmo_hit = 0;
    cyc();
    ex_mem_valid = 1; ex_mem_load = ld; ex_mem_store = st; ex_mem_size = sz;
    ex_mem_unsigned = uns; ex_mem_addr = a; ex_mem_wdata = wd; dm_ack = 0;
    e_stall = ismem & ~mis; e_req = 0; e_done = 0; e_mis = ismem & mis; e_berr = 0;
    chk_bus = 0; e_out = m_out;
    if (!ismem || mis) begin
      @(negedge clk);
      #1;
      return;
    end
    e_addr = a & 32'hFFFF_FFFC; e_be = model_be(sz, a); e_wdata = model_wd(sz, wd); e_we = st;
    for (int j = 0; j <= rst_at; j++) begin
      cyc();
      if (j == rst_at) begin
        chk("stall_before_rst", 32'(mem_stall), 32'd1);
        rst = 0; ex_mem_valid = 0; dm_ack = 0;
        e_stall = 0; e_req = 0; e_done = 0; e_mis = 0; e_berr = 0;
        chk_bus = 1; e_addr = 0; e_be = 0; e_wdata = 0; e_we = 0; m_out = 0; e_out = 0;
        @(negedge clk);
        #1;
        cyc();
        rst = 1;
        @(negedge clk);
        #1;
        return;
      end
      ex_mem_valid = 0; ex_mem_addr = 32'hFFFF_FFF1 ^ j; ex_mem_wdata = ~wd; ex_mem_size = ~sz;
      dm_ack = (j == k); dm_rdata = (j == k) ? rd : 32'h5A5A_5A5A;
      e_stall = 1; e_req = 1; e_done = 0; e_mis = 0; chk_bus = 1; e_out = m_out;
      if (j == k) break;
`ifdef LSU_TIMEOUT_EN
      if (j == TMO - 1) begin
        tmo_hit = 1;
        break;
      end
`endif
    end
    cyc();
    dm_ack = 0; dm_rdata = 0;
    e_req = 0; e_stall = 0; e_done = 1; chk_bus = 0; e_berr = tmo_hit;
    if (ld && !st) m_out = tmo_hit ? 32'h0 : model_load(sz, uns, a, rd);
    e_out = m_out;
    @(negedge clk);
    #1;
  endtask

  int s0, r0;

  initial begin
    chk_en = 1;
    repeat (3) @(negedge clk);
    #1;
    cyc();
    rst = 1;
    @(negedge clk);
    #1;

    s0 = n_stall_seen;
    access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h1234_5678, 2, 1000);
    chk("t1_stall_cycles", n_stall_seen - s0, 4);
    chk("t1_out", mem_DM_out, 32'h1234_5678);
    chk("t1_addr", last_addr, 32'h100);
    chk("t1_be", 32'(last_be), 32'hF);

    access(1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF_7F01, 0, 1000);
    chk("t2_be", 32'(last_be), 32'h8);
    chk("t2_signed", mem_DM_out, 32'hFFFF_FF80);
    access(1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF_7F01, 0, 1000);
    chk("t2_unsigned", mem_DM_out, 32'h0000_0080);

    s0 = n_stall_seen;
    access(0, 1, 2'b01, 0, 32'h302, 32'h0000_ABCD, 32'h0, 0, 1000);
    chk("t3_stall_cycles", n_stall_seen - s0, 2);
    chk("t3_we", 32'(last_we), 32'd1);
    chk("t3_be", 32'(last_be), 32'hC);
    chk("t3_wdata", last_wdata, 32'hABCD_ABCD);
    chk("t3_addr", last_addr, 32'h300);
    chk("t3_out_kept", mem_DM_out, 32'h0000_0080);

    access(1, 1, 2'b00, 0, 32'h001, 32'h1234_5677, 32'hFFFF_FFFF, 1, 1000);
    chk("both_is_store_we", 32'(last_we), 32'd1);
    chk("both_wdata", last_wdata, 32'h7777_7777);
    chk("both_out_kept", mem_DM_out, 32'h0000_0080);

    access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_1234, 0, 1000);
    chk("half_signed", mem_DM_out, 32'hFFFF_8001);
    access(1, 0, 2'b11, 1, 32'h008, 32'h0, 32'hDEAD_BEEF, 1, 1000);
    chk("size11_word", mem_DM_out, 32'hDEAD_BEEF);

    r0 = n_req_seen;
    s0 = n_stall_seen;
    idle(2, 1);
    access(0, 0, 2'b10, 0, 32'h010, 32'h0, 32'h0, 0, 1000);
    access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 1000);
    access(0, 1, 2'b01, 0, 32'h003, 32'h0, 32'h0, 0, 1000);
    idle(3, 0);
    chk("t4_no_req", n_req_seen - r0, 0);
    chk("t4_no_stall", n_stall_seen - s0, 0);

    access(1, 0, 2'b10, 0, 32'h040, 32'h0, 32'h1111_1111, 10, 3);
    chk("t5_out_reset", mem_DM_out, 32'h0);
    access(1, 0, 2'b10, 0, 32'h000, 32'h0, 32'hCAFE_F00D, 1, 1000);
    chk("t5_after_reset", mem_DM_out, 32'hCAFE_F00D);

    access(1, 0, 2'b10, 0, 32'h080, 32'h0, 32'h0, -1, 100);
    chk("t6_out", mem_DM_out, 32'h0);
    idle(2, 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
